// File: rtl/vsram_sched_pkg.sv
// Shared definitions for the VSRAM row scheduler.
//   MAX_SEQ_LENGTH : VSRAM depth (macro MAX_SEQ_LENGTH, defaults to 16)
//   ROW_W          : width of row index / sequence length fields
//   PASS_W         : width of the pass (Q tile) counter
//   VSRAM_SCHED_STATE_T : scheduler FSM states
//   ROW_IDX_T, PASS_T   : field typedefs
//   sat_inc32()    : saturating 32-bit increment used by the optional
//                    stall counters (VSRAM_SCHED_PERF_EN)
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 16
`endif

package vsram_sched_pkg;

  localparam int MAX_SEQ_LENGTH = `MAX_SEQ_LENGTH;
  localparam int ROW_W          = $clog2(MAX_SEQ_LENGTH) + 1;
  localparam int PASS_W         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } VSRAM_SCHED_STATE_T;

  typedef logic [ROW_W-1:0]  ROW_IDX_T;
  typedef logic [PASS_W-1:0] PASS_T;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vsram_credit_ctr.sv
// Credit pool for the VSRAM: one credit per free VSRAM entry.
// Ports:
//   clk, rst : clock and synchronous active-high reset (reloads NUM_ENTRIES)
//   inc      : return one credit (a row left the VSRAM)
//   dec      : consume one credit (a row request was issued)
//   zero     : no credits left
// Simultaneous inc and dec leave the count unchanged. The count is clamped
// at both ends so a misbehaving neighbour cannot wrap it.
module vsram_credit_ctr #(
  parameter int NUM_ENTRIES = 16,
  parameter int CW          = $clog2(NUM_ENTRIES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= CW'(NUM_ENTRIES);
    end else if (inc && !dec && (count_reg != CW'(NUM_ENTRIES))) begin
      count_reg <= count_reg + CW'(1);
    end else if (dec && !inc && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/vsram_sched.sv
// VSRAM row scheduler for one attention job.
// Issues V-row read requests (rows 0..seq_len-1, in order) to the memory
// controller, forwards returned rows into the VSRAM, lets the PE array drain
// the VSRAM and repeats the whole row sequence once per pass (Q tile).
// A credit pool sized to the VSRAM depth bounds outstanding rows so the
// VSRAM can never overflow.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, seq_len, num_passes : job launch (fields sampled on start in IDLE)
//   mem_req_valid/ready/row  : row request handshake to memory controller
//   mem_rsp_valid            : returned row data (request order)
//   vsram_write_en           : VSRAM write strobe (mirrors mem_rsp_valid)
//   vsram_ready, vsram_rd_valid : VSRAM not-full / not-empty
//   pe_ready, vsram_read_en  : PE array ready / VSRAM pop strobe
//   pass_done, done          : 1-cycle completion pulses
//   busy                     : job in progress
//   overflow_err             : sticky, response arrived while VSRAM full
// Optional macro VSRAM_SCHED_PERF_EN adds stall_mem_cnt / stall_pe_cnt.
module vsram_sched
  import vsram_sched_pkg::*;
#(
  parameter int NUM_ENTRIES = MAX_SEQ_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  seq_len,
  input  logic [PASS_W-1:0] num_passes,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ROW_W-1:0]  mem_req_row,
  input  logic              mem_rsp_valid,
  output logic              vsram_write_en,
  input  logic              vsram_ready,
  input  logic              vsram_rd_valid,
  input  logic              pe_ready,
  output logic              vsram_read_en,
  output logic              pass_done,
  output logic              done,
  output logic              busy,
  output logic              overflow_err
`ifdef VSRAM_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_mem_cnt,
  output logic [31:0]       stall_pe_cnt
`endif
);

  VSRAM_SCHED_STATE_T state_reg, state_next;
  ROW_IDX_T seq_len_reg, seq_len_next;
  PASS_T    num_passes_reg, num_passes_next;
  ROW_IDX_T issued_reg, issued_next;
  ROW_IDX_T consumed_reg, consumed_next;
  PASS_T    pass_reg, pass_next;
  logic     noop_done_reg, noop_done_next;
  logic     overflow_reg;
  logic     credit_zero;
  logic     req_fire;

  assign req_fire       = mem_req_valid && mem_req_ready;
  assign busy           = (state_reg != IDLE);
  assign vsram_read_en  = pe_ready && vsram_rd_valid && busy;
  // Credits guarantee space, so writes are never gated; overflow is only flagged.
  assign vsram_write_en = mem_rsp_valid;
  assign mem_req_row    = issued_reg;
  assign overflow_err   = overflow_reg;

  vsram_credit_ctr #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_credit (
    .clk (clk),
    .rst (rst),
    .inc (vsram_read_en),
    .dec (req_fire),
    .zero(credit_zero)
  );

  always_comb begin
    state_next      = state_reg;
    seq_len_next    = seq_len_reg;
    num_passes_next = num_passes_reg;
    issued_next     = issued_reg;
    consumed_next   = consumed_reg;
    pass_next       = pass_reg;
    noop_done_next  = 1'b0;
    mem_req_valid   = 1'b0;
    pass_done       = 1'b0;
    done            = noop_done_reg;

    // Rows leaving the VSRAM count toward the current pass.
    if (((state_reg == ISSUE) || (state_reg == DRAIN)) && vsram_read_en) begin
      consumed_next = consumed_reg + ROW_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          if ((seq_len != '0) && (num_passes != '0)) begin
            seq_len_next    = seq_len;
            num_passes_next = num_passes;
            issued_next     = '0;
            consumed_next   = '0;
            pass_next       = '0;
            state_next      = ISSUE;
          end else begin
            // Empty job: acknowledge with a done pulse without leaving IDLE.
            noop_done_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        mem_req_valid = !credit_zero && (issued_reg < seq_len_reg);
        if (req_fire) begin
          issued_next = issued_reg + ROW_W'(1);
        end
        if (issued_reg == seq_len_reg) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Next pass is only started once every row of this pass is consumed.
        if (consumed_reg == seq_len_reg) begin
          pass_done = 1'b1;
          if (pass_reg == (num_passes_reg - PASS_W'(1))) begin
            state_next = DONE;
          end else begin
            pass_next     = pass_reg + PASS_W'(1);
            issued_next   = '0;
            consumed_next = '0;
            state_next    = ISSUE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      seq_len_reg    <= '0;
      num_passes_reg <= '0;
      issued_reg     <= '0;
      consumed_reg   <= '0;
      pass_reg       <= '0;
      noop_done_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      seq_len_reg    <= seq_len_next;
      num_passes_reg <= num_passes_next;
      issued_reg     <= issued_next;
      consumed_reg   <= consumed_next;
      pass_reg       <= pass_next;
      noop_done_reg  <= noop_done_next;
      if (mem_rsp_valid && !vsram_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

`ifdef VSRAM_SCHED_PERF_EN
  logic        start_accept;
  logic [31:0] stall_mem_cnt_reg;
  logic [31:0] stall_pe_cnt_reg;

  assign start_accept = (state_reg == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      stall_mem_cnt_reg <= '0;
      stall_pe_cnt_reg  <= '0;
    end else begin
      if (mem_req_valid && !mem_req_ready) begin
        stall_mem_cnt_reg <= sat_inc32(stall_mem_cnt_reg);
      end
      if (busy && vsram_rd_valid && !pe_ready) begin
        stall_pe_cnt_reg <= sat_inc32(stall_pe_cnt_reg);
      end
    end
  end

  assign stall_mem_cnt = stall_mem_cnt_reg;
  assign stall_pe_cnt  = stall_pe_cnt_reg;
`endif

endmodule

// File: tb/tb_vsram_sched.sv
// Bench for vsram_sched (NUM_ENTRIES = 4). A small environment model plays
// the memory controller (1-cycle response latency) and the VSRAM (occupancy
// counter); job vectors come from a table, corner cases are hand sequences.
module tb_vsram_sched;
  import vsram_sched_pkg::*;

  localparam int NE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ROW_W-1:0]  seq_len;
  logic [PASS_W-1:0] num_passes;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ROW_W-1:0]  mem_req_row;
  logic              mem_rsp_valid;
  logic              vsram_write_en;
  logic              vsram_ready;
  logic              vsram_rd_valid;
  logic              pe_ready;
  logic              vsram_read_en;
  logic              pass_done;
  logic              done;
  logic              busy;
  logic              overflow_err;
`ifdef VSRAM_SCHED_PERF_EN
  logic [31:0]       stall_mem_cnt;
  logic [31:0]       stall_pe_cnt;
`endif

  always #5 clk = ~clk;

  vsram_sched #(.NUM_ENTRIES(NE)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seq_len       (seq_len),
    .num_passes    (num_passes),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_row   (mem_req_row),
    .mem_rsp_valid (mem_rsp_valid),
    .vsram_write_en(vsram_write_en),
    .vsram_ready   (vsram_ready),
    .vsram_rd_valid(vsram_rd_valid),
    .pe_ready      (pe_ready),
    .vsram_read_en (vsram_read_en),
    .pass_done     (pass_done),
    .done          (done),
    .busy          (busy),
    .overflow_err  (overflow_err)
`ifdef VSRAM_SCHED_PERF_EN
    ,
    .stall_mem_cnt (stall_mem_cnt),
    .stall_pe_cnt  (stall_pe_cnt)
`endif
  );

  typedef struct {
    int seq;
    int passes;
    int ready_mode;   // 0: mem_req_ready always 1, 1: toggles every cycle
    int pe_block;     // cycles pe_ready held low after launch
    int exp_blocked;  // requests expected while PEs are blocked
    int exp_reqs;
    int exp_pd;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // environment model
  int occ, rsp_pending, cycle_cnt;
  int exp_row, cur_seq;
  int n_req, n_read, n_pd, n_done;
  int last_read_cyc, last_pd_cyc, done_cyc;
  int ready_mode;
  bit pe_ready_val, force_ovf, stalled_prev;
  logic [ROW_W-1:0] held_row;
  logic last_valid, last_busy, last_done, last_pd, last_ovf, last_we, last_re;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cycle_cnt);
    end
  endtask

  task automatic clear_env();
    occ = 0;
    rsp_pending = 0;
    stalled_prev = 1'b0;
  endtask

  // One clock cycle: drive inputs from the model, sample at negedge,
  // update the model, then step past the rising edge.
  task automatic cyc();
    mem_rsp_valid  = force_ovf || (rsp_pending != 0);
    vsram_ready    = !force_ovf && (occ < NE);
    vsram_rd_valid = (occ != 0);
    mem_req_ready  = (ready_mode == 0) ? 1'b1 : cycle_cnt[0];
    pe_ready       = pe_ready_val;
    @(negedge clk);
    last_valid = mem_req_valid;
    last_busy  = busy;
    last_done  = done;
    last_pd    = pass_done;
    last_ovf   = overflow_err;
    last_we    = vsram_write_en;
    last_re    = vsram_read_en;
    if (stalled_prev) begin
      check("row_hold_valid", 32'(mem_req_valid), 32'd1);
      check("row_hold_row", 32'(mem_req_row), 32'(held_row));
    end
    stalled_prev = mem_req_valid && !mem_req_ready;
    held_row = mem_req_row;
    if (mem_rsp_valid && !force_ovf && rsp_pending != 0) rsp_pending--;
    if (mem_req_valid && mem_req_ready) begin
      $display("REQ  cycle=%0d row=%0d", cycle_cnt, mem_req_row);
      check("req_row", 32'(mem_req_row), 32'(exp_row));
      exp_row = (exp_row + 1 == cur_seq) ? 0 : exp_row + 1;
      rsp_pending++;
      n_req++;
    end
    if (vsram_write_en) occ++;
    if (vsram_read_en) begin
      occ--;
      n_read++;
      last_read_cyc = cycle_cnt;
    end
    if (pass_done) begin
      $display("PASS cycle=%0d", cycle_cnt);
      check("pass_done_lat", 32'(cycle_cnt), 32'(last_read_cyc + 1));
      n_pd++;
      last_pd_cyc = cycle_cnt;
    end
    if (done) begin
      n_done++;
      done_cyc = cycle_cnt;
    end
    @(posedge clk);
    #1;
    cycle_cnt++;
  endtask

  task automatic run_job(input vec_t v);
    exp_row = 0; cur_seq = v.seq;
    n_req = 0; n_read = 0; n_pd = 0; n_done = 0;
    last_read_cyc = -10; last_pd_cyc = -10; done_cyc = -1;
    ready_mode = v.ready_mode;
    seq_len = ROW_W'(v.seq);
    num_passes = PASS_W'(v.passes);
    pe_ready_val = (v.pe_block == 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("first_req_latency", 32'(last_valid), 32'd1);
    for (int k = 0; k < 3000 && n_done == 0; k++) begin
      pe_ready_val = (k >= v.pe_block);
      if (v.pe_block > 0 && k == v.pe_block) begin
        check("blocked_reqs", 32'(n_req), 32'(v.exp_blocked));
        check("blocked_valid", 32'(last_valid), 32'd0);
      end
      cyc();
    end
    cyc();
    check("job_reqs", 32'(n_req), 32'(v.exp_reqs));
    check("job_reads", 32'(n_read), 32'(v.exp_reqs));
    check("job_pass_done", 32'(n_pd), 32'(v.exp_pd));
    check("job_done", 32'(n_done), 32'd1);
    check("done_lat", 32'(done_cyc), 32'(last_pd_cyc + 1));
    check("busy_after", 32'(last_busy), 32'd0);
    check("no_overflow", 32'(last_ovf), 32'd0);
    $display("JOB  seq=%0d passes=%0d reqs=%0d pass_done=%0d done_cycle=%0d",
             v.seq, v.passes, n_req, n_pd, done_cyc);
  endtask

  initial begin
    vecs[0] = '{seq: 4,  passes: 1, ready_mode: 0, pe_block: 0,  exp_blocked: 0, exp_reqs: 4,  exp_pd: 1};
    vecs[1] = '{seq: 10, passes: 1, ready_mode: 0, pe_block: 20, exp_blocked: 4, exp_reqs: 10, exp_pd: 1};
    vecs[2] = '{seq: 3,  passes: 3, ready_mode: 0, pe_block: 0,  exp_blocked: 0, exp_reqs: 9,  exp_pd: 3};
    vecs[3] = '{seq: 5,  passes: 2, ready_mode: 1, pe_block: 0,  exp_blocked: 0, exp_reqs: 10, exp_pd: 2};
    vecs[4] = '{seq: 1,  passes: 2, ready_mode: 1, pe_block: 0,  exp_blocked: 0, exp_reqs: 2,  exp_pd: 2};
    vecs[5] = '{seq: 12, passes: 1, ready_mode: 0, pe_block: 0,  exp_blocked: 0, exp_reqs: 12, exp_pd: 1};

    rst = 1'b1; start = 1'b0; seq_len = '0; num_passes = '0;
    ready_mode = 0; pe_ready_val = 1'b1; force_ovf = 1'b0;
    cycle_cnt = 0; exp_row = 0; cur_seq = 1;
    n_req = 0; n_read = 0; n_pd = 0; n_done = 0;
    last_read_cyc = -10; last_pd_cyc = -10; done_cyc = -1;
    clear_env();

    // reset state
    cyc();
    cyc();
    check("rst_valid", 32'(last_valid), 32'd0);
    check("rst_busy", 32'(last_busy), 32'd0);
    check("rst_done", 32'(last_done), 32'd0);
    check("rst_pass_done", 32'(last_pd), 32'd0);
    check("rst_ovf", 32'(last_ovf), 32'd0);
    rst = 1'b0;
    cyc();
    check("idle_valid", 32'(last_valid), 32'd0);
    check("idle_busy", 32'(last_busy), 32'd0);
    check("idle_read_en", 32'(last_re), 32'd0);

    // table-driven jobs
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i]);
    end

    // reset in the middle of ISSUE with one credit left
    seq_len = ROW_W'(10); num_passes = PASS_W'(1);
    ready_mode = 0; pe_ready_val = 1'b0;
    exp_row = 0; cur_seq = 10; n_req = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 20 && n_req < 3; k++) cyc();
    check("pre_rst_reqs", 32'(n_req), 32'd3);
    check("pre_rst_busy", 32'(last_busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_env();
    cyc();
    check("midrst_valid", 32'(last_valid), 32'd0);
    check("midrst_busy", 32'(last_busy), 32'd0);
    check("midrst_done", 32'(last_done), 32'd0);
    check("midrst_pass_done", 32'(last_pd), 32'd0);
    // full credit pool again: exactly NE requests while PEs are blocked
    run_job(vecs[1]);

    // empty jobs
    seq_len = '0; num_passes = PASS_W'(3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("noop_done_early", 32'(last_done), 32'd0);
    cyc();
    check("noop_done", 32'(last_done), 32'd1);
    check("noop_busy", 32'(last_busy), 32'd0);
    check("noop_req", 32'(last_valid), 32'd0);
    cyc();
    check("noop_done_clear", 32'(last_done), 32'd0);
    seq_len = ROW_W'(5); num_passes = '0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("noop2_done", 32'(last_done), 32'd1);
    check("noop2_req", 32'(last_valid), 32'd0);
    cyc();
    check("noop2_idle_req", 32'(last_valid), 32'd0);
    $display("NOOP cycle=%0d", cycle_cnt);

    // response while VSRAM full
    force_ovf = 1'b1;
    cyc();
    force_ovf = 1'b0;
    occ = 0;
    check("ovf_write_fwd", 32'(last_we), 32'd1);
    check("ovf_before", 32'(last_ovf), 32'd0);
    cyc();
    check("ovf_set", 32'(last_ovf), 32'd1);
    cyc();
    check("ovf_sticky", 32'(last_ovf), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_env();
    cyc();
    check("ovf_rst_clear", 32'(last_ovf), 32'd0);
    $display("OVF  cycle=%0d", cycle_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
